// File: rtl/fifo_access_ctrl_pkg.sv
// Shared FIFO definitions: depth default, address/count widths and the
// width-derivation helper, so storage and access control agree on sizes.
package fifo_access_ctrl_pkg;

    localparam int unsigned DEFAULT_MEM_DEPTH = 4;

    // Smallest n such that 2**n >= value (value >= 2 in practice).
    function automatic int unsigned CeilLog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned PTR_W = CeilLog2(DEFAULT_MEM_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Accepted-operation classes seen by the occupancy counter.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: memory pointer that advances on inc and wraps from
// MEM_DEPTH-1 back to 0 by explicit compare (works for any depth).
module fifo_wrap_ptr
    import fifo_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int unsigned ADDR_W    = CeilLog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Next pointer: hold, increment, or wrap at the last entry.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    // Pointer register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: gates raw push/pop requests against the registered
// occupancy, drives memory strobes/addresses and keeps sticky error flags.
module fifo_access_ctrl
    import fifo_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int unsigned ADDR_W    = CeilLog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic              clear_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned   CW        = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(MEM_DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_valid_q;
    logic          full_w, empty_w;
    logic          push_ok, pop_ok;
    fifo_op_e      op;

    // Occupancy flags come from the registered count only.
    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    // Acceptance: strobes are suppressed while reset is held low.
    always_comb begin
        push_ok = reset & push_req & ~full_w;
        pop_ok  = reset & pop_req  & ~empty_w;
        op      = fifo_op_e'({push_ok, pop_ok});
    end

    // Next occupancy and sticky error flags (a new error beats clear_err).
    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_PUSH: count_d = count_q + CW'(1);
            OP_POP:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d  = (push_req & full_w)  | (overflow_q  & ~clear_err);
        underflow_d = (pop_req  & empty_w) | (underflow_q & ~clear_err);
    end

    // Count, error flags and read-valid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= pop_ok;
        end
    end

    fifo_wrap_ptr #(.MEM_DEPTH(MEM_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (wr_addr)
    );

    fifo_wrap_ptr #(.MEM_DEPTH(MEM_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rd_addr)
    );

    assign wr_en     = push_ok;
    assign rd_en     = pop_ok;
    assign rd_valid  = rd_valid_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: depth-4 and depth-5 instances share stimulus;
// a behavioural FIFO model queues expected outputs per cycle.
module tb_fifo_access_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic push_req = 1'b0;
    logic pop_req = 1'b0;
    logic clear_err = 1'b0;

    logic       wr_en4, rd_en4, rd_valid4, full4, empty4, overflow4, underflow4;
    logic [1:0] wr_addr4, rd_addr4;
    logic [2:0] count4;
    logic       wr_en5, rd_en5, rd_valid5, full5, empty5, overflow5, underflow5;
    logic [2:0] wr_addr5, rd_addr5;
    logic [3:0] count5;

    int n_checks = 0;
    int n_pass = 0;

    // model state, index 0 = depth 4, index 1 = depth 5
    int   m_cnt[2], m_wp[2], m_rp[2];
    logic m_ovf[2], m_unf[2], m_rdv[2];
    logic [16:0] q4[$];
    logic [16:0] q5[$];

    always #5 clk = ~clk;

    fifo_access_ctrl #(.MEM_DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .clear_err(clear_err), .wr_en(wr_en4), .wr_addr(wr_addr4), .rd_en(rd_en4),
        .rd_addr(rd_addr4), .rd_valid(rd_valid4), .full(full4), .empty(empty4),
        .count(count4), .overflow(overflow4), .underflow(underflow4)
    );

    fifo_access_ctrl #(.MEM_DEPTH(5)) u_dut5 (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .clear_err(clear_err), .wr_en(wr_en5), .wr_addr(wr_addr5), .rd_en(rd_en5),
        .rd_addr(rd_addr5), .rd_valid(rd_valid5), .full(full5), .empty(empty5),
        .count(count5), .overflow(overflow5), .underflow(underflow5)
    );

    // packed view: {count[4], wa[3], ra[3], full, empty, ovf, unf, rdv, we, re}
    function automatic logic [16:0] obs4();
        return {1'b0, count4, 1'b0, wr_addr4, 1'b0, rd_addr4, full4, empty4,
                overflow4, underflow4, rd_valid4, wr_en4, rd_en4};
    endfunction

    function automatic logic [16:0] obs5();
        return {count5, wr_addr5, rd_addr5, full5, empty5,
                overflow5, underflow5, rd_valid5, wr_en5, rd_en5};
    endfunction

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    // Drive one cycle of requests; queue the expected outputs for it.
    task automatic drive(input logic p, input logic q, input logic c);
        logic fl, em, pok, qok;
        logic [16:0] e;
        @(negedge clk);
        push_req = p; pop_req = q; clear_err = c;
        for (int k = 0; k < 2; k++) begin
            fl  = (m_cnt[k] == dep(k));
            em  = (m_cnt[k] == 0);
            pok = p && !fl;
            qok = q && !em;
            e = {4'(m_cnt[k]), 3'(m_wp[k]), 3'(m_rp[k]), fl, em,
                 m_ovf[k], m_unf[k], m_rdv[k], pok, qok};
            if (k == 0) q4.push_back(e); else q5.push_back(e);
            m_ovf[k] = (p && fl) || (m_ovf[k] && !c);
            m_unf[k] = (q && em) || (m_unf[k] && !c);
            m_cnt[k] = m_cnt[k] + (pok ? 1 : 0) - (qok ? 1 : 0);
            if (pok) m_wp[k] = (m_wp[k] == dep(k) - 1) ? 0 : m_wp[k] + 1;
            if (qok) m_rp[k] = (m_rp[k] == dep(k) - 1) ? 0 : m_rp[k] + 1;
            m_rdv[k] = qok;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
            m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_rdv[k] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; push_req = 1'b0; pop_req = 1'b0; clear_err = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] stim[$] = '{3'b010, 3'b100, 3'b100, 3'b100};
        logic [16:0] e4, e5;
        #2 reset = 1'b0; push_req = 1'b1; pop_req = 1'b1;
        #1;
        n_checks++;
        if (obs4() !== 17'h00020) $display("FAIL reset_por d4 got %h exp %h", obs4(), 17'h00020);
        else n_pass++;
        n_checks++;
        if (obs5() !== 17'h00020) $display("FAIL reset_por d5 got %h exp %h", obs5(), 17'h00020);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1; push_req = 1'b0; pop_req = 1'b0;
        model_clear();
        foreach (stim[i]) begin
            drive(stim[i][2], stim[i][1], stim[i][0]);
            e4 = q4.pop_front(); e5 = q5.pop_front();
            n_checks++;
            if (obs4() !== e4) $display("FAIL reset_pre d4 step %0d got %h exp %h", i, obs4(), e4);
            else n_pass++;
            n_checks++;
            if (obs5() !== e5) $display("FAIL reset_pre d5 step %0d got %h exp %h", i, obs5(), e5);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (count4 !== 3'd3 || underflow4 !== 1'b1)
            $display("FAIL reset_midstream_pre got count=%0d unf=%b exp count=3 unf=1", count4, underflow4);
        else n_pass++;
        reset = 1'b0; push_req = 1'b1; pop_req = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (obs4() !== 17'h00020) $display("FAIL reset_mid d4 got %h exp %h", obs4(), 17'h00020);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({wr_en4, rd_en4, wr_en5, rd_en5, count4} !== 7'd0)
            $display("FAIL reset_hold got en=%b%b%b%b count=%0d exp 0", wr_en4, rd_en4, wr_en5, rd_en5, count4);
        else n_pass++;
        reset = 1'b1; push_req = 1'b0; pop_req = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [2:0] stim[$] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                                3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
        logic [16:0] e4, e5;
        apply_reset();
        foreach (stim[i]) begin
            drive(stim[i][2], stim[i][1], stim[i][0]);
            e4 = q4.pop_front(); e5 = q5.pop_front();
            n_checks++;
            if (obs4() !== e4) $display("FAIL fill d4 step %0d got %h exp %h", i, obs4(), e4);
            else n_pass++;
            n_checks++;
            if (obs5() !== e5) $display("FAIL fill d5 step %0d got %h exp %h", i, obs5(), e5);
            else n_pass++;
            if (i < 4) begin
                n_checks++;
                if (wr_addr4 !== 2'(i) || wr_en4 !== 1'b1)
                    $display("FAIL fill_waddr step %0d got %0d/%b exp %0d/1", i, wr_addr4, wr_en4, i);
                else n_pass++;
            end else if (i == 4) begin
                n_checks++;
                if (full4 !== 1'b1 || wr_en4 !== 1'b0)
                    $display("FAIL fill_full got full=%b wr_en=%b exp 1/0", full4, wr_en4);
                else n_pass++;
            end else if (i == 5) begin
                n_checks++;
                if (overflow4 !== 1'b1) $display("FAIL fill_overflow got %b exp 1", overflow4);
                else n_pass++;
            end else if (i < 10) begin
                n_checks++;
                if (rd_addr4 !== 2'(i - 6)) $display("FAIL drain_raddr step %0d got %0d exp %0d", i, rd_addr4, i - 6);
                else n_pass++;
            end else begin
                n_checks++;
                if (empty4 !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty4);
                else n_pass++;
            end
        end
    endtask

    task automatic test_nonpow2();
        logic [2:0] stim[$] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                3'b010, 3'b010, 3'b010, 3'b100, 3'b100,
                                3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
        logic [16:0] e4, e5;
        int peak = 0;
        logic [2:0] pw = '0, pr = '0;
        bit wwrap = 0, rwrap = 0;
        apply_reset();
        foreach (stim[i]) begin
            drive(stim[i][2], stim[i][1], stim[i][0]);
            e4 = q4.pop_front(); e5 = q5.pop_front();
            n_checks++;
            if (obs5() !== e5) $display("FAIL np2 d5 step %0d got %h exp %h", i, obs5(), e5);
            else n_pass++;
            n_checks++;
            if (obs4() !== e4) $display("FAIL np2 d4 step %0d got %h exp %h", i, obs4(), e4);
            else n_pass++;
            if (int'(count5) > peak) peak = int'(count5);
            if (pw == 3'd4 && wr_addr5 == 3'd0) wwrap = 1;
            if (pr == 3'd4 && rd_addr5 == 3'd0) rwrap = 1;
            pw = wr_addr5; pr = rd_addr5;
        end
        n_checks++;
        if (peak != 5) $display("FAIL np2_peak got %0d exp 5", peak);
        else n_pass++;
        n_checks++;
        if (!(wwrap && rwrap)) $display("FAIL np2_wrap got w=%0d r=%0d exp 1 1", wwrap, rwrap);
        else n_pass++;
        n_checks++;
        if (wr_addr5 !== 3'd2 || rd_addr5 !== 3'd2 || empty5 !== 1'b1)
            $display("FAIL np2_final got wa=%0d ra=%0d empty=%b exp 2 2 1", wr_addr5, rd_addr5, empty5);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [2:0] stim[$] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b110,
                                3'b100, 3'b100, 3'b110, 3'b000};
        logic [16:0] e4, e5;
        apply_reset();
        foreach (stim[i]) begin
            drive(stim[i][2], stim[i][1], stim[i][0]);
            e4 = q4.pop_front(); e5 = q5.pop_front();
            n_checks++;
            if (obs4() !== e4) $display("FAIL simul d4 step %0d got %h exp %h", i, obs4(), e4);
            else n_pass++;
            n_checks++;
            if (obs5() !== e5) $display("FAIL simul d5 step %0d got %h exp %h", i, obs5(), e5);
            else n_pass++;
            if (i >= 2 && i <= 5) begin
                n_checks++;
                if (count4 !== 3'd2) $display("FAIL simul_b2b step %0d got count=%0d exp 2", i, count4);
                else n_pass++;
            end
        end
        n_checks++;
        if (count4 !== 3'd3 || overflow4 !== 1'b1 || wr_addr4 !== 2'd3 || rd_addr4 !== 2'd0)
            $display("FAIL simul_full got c=%0d ovf=%b wa=%0d ra=%0d exp 3 1 3 0",
                     count4, overflow4, wr_addr4, rd_addr4);
        else n_pass++;
        apply_reset();
        drive(1'b1, 1'b1, 1'b0);
        e4 = q4.pop_front(); e5 = q5.pop_front();
        n_checks++;
        if ({wr_en4, rd_en4} !== 2'b10) $display("FAIL simul_empty_en got %b%b exp 10", wr_en4, rd_en4);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0);
        e4 = q4.pop_front(); e5 = q5.pop_front();
        n_checks++;
        if (count4 !== 3'd1 || underflow4 !== 1'b1 || obs4() !== e4)
            $display("FAIL simul_empty got c=%0d unf=%b obs=%h exp 1 1 %h", count4, underflow4, obs4(), e4);
        else n_pass++;
    endtask

    task automatic test_error_flags();
        // step: pop-empty, idle, push, pop, idle, clear, idle, pop-empty+clear, idle
        logic [2:0] stim[$] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b000,
                                3'b001, 3'b000, 3'b011, 3'b000};
        logic       unf_exp[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [16:0] e4, e5;
        apply_reset();
        foreach (stim[i]) begin
            drive(stim[i][2], stim[i][1], stim[i][0]);
            e4 = q4.pop_front(); e5 = q5.pop_front();
            n_checks++;
            if (obs4() !== e4) $display("FAIL errflag d4 step %0d got %h exp %h", i, obs4(), e4);
            else n_pass++;
            n_checks++;
            if (underflow4 !== unf_exp[i] || underflow5 !== unf_exp[i])
                $display("FAIL errflag_unf step %0d got %b/%b exp %b", i, underflow4, underflow5, unf_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rd_valid();
        logic [16:0] e4, e5;
        logic prev_re = 1'b0;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            if (i == 0 || i[0] == 1'b0) drive(1'b1, 1'b0, 1'b0);
            else drive(1'b0, 1'b1, 1'b0);
            e4 = q4.pop_front(); e5 = q5.pop_front();
            n_checks++;
            if (obs4() !== e4) $display("FAIL rdv d4 step %0d got %h exp %h", i, obs4(), e4);
            else n_pass++;
            n_checks++;
            if (rd_valid4 !== prev_re) $display("FAIL rdv_align step %0d got %b exp %b", i, rd_valid4, prev_re);
            else n_pass++;
            prev_re = e4[0];
        end
        drive(1'b0, 1'b0, 1'b0);
        e4 = q4.pop_front(); e5 = q5.pop_front();
        n_checks++;
        if (rd_valid4 !== prev_re || obs5() !== e5)
            $display("FAIL rdv_tail got %b/%h exp %b/%h", rd_valid4, obs5(), prev_re, e5);
        else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_wrap();
        test_nonpow2();
        test_simultaneous();
        test_error_flags();
        test_rd_valid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks, exp completion", n_checks);
        $fatal(1);
    end

endmodule
